// File: rtl/fifo_multichannel_drain_if.sv
// Stream bundle between the per-channel FWFT FIFO read ports, the drain arbiter
// and the downstream readout stage. master = arbiter side, slave = environment side.
interface fifo_multichannel_drain_if #(
  parameter int RAM_WIDTH = 32,
  parameter int FIFOS_CNT = 50
);
  localparam int CH_W = $clog2(FIFOS_CNT);

  logic [FIFOS_CNT-1:0]           i_rd_valid_channels;
  logic [FIFOS_CNT*RAM_WIDTH-1:0] i_rd_data_channels;
  logic [FIFOS_CNT-1:0]           i_empty_next_channels;
  logic [FIFOS_CNT-1:0]           o_rd_en_channels;
  logic                           o_valid;
  logic [RAM_WIDTH-1:0]           o_data;
  logic [CH_W-1:0]                o_channel;
  logic                           o_last;
  logic                           i_ready;

  modport master (
    input  i_rd_valid_channels, i_rd_data_channels, i_empty_next_channels, i_ready,
    output o_rd_en_channels, o_valid, o_data, o_channel, o_last
  );

  modport slave (
    output i_rd_valid_channels, i_rd_data_channels, i_empty_next_channels, i_ready,
    input  o_rd_en_channels, o_valid, o_data, o_channel, o_last
  );
endinterface

// File: rtl/fifo_multichannel_drain.sv
// Round-robin burst drain of multichannel FWFT FIFOs onto one valid/ready stream.
// Optional macro FIFO_DRAIN_CHANNEL_MASK_EN adds i_enable_channels to gate channel eligibility.
module fifo_multichannel_drain #(
  parameter int RAM_WIDTH = 32,
  parameter int FIFOS_CNT = 50,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef FIFO_DRAIN_CHANNEL_MASK_EN
  input  logic [FIFOS_CNT-1:0]     i_enable_channels,
`endif
  fifo_multichannel_drain_if.master drain
);

  localparam int CH_W  = $clog2(FIFOS_CNT);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(FIFOS_CNT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    S_SCAN  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CH_W-1:0]      r_rr_ptr;
  logic [CH_W-1:0]      r_grant;
  logic [CNT_W-1:0]     r_cnt;

  logic                 r_valid;
  logic [RAM_WIDTH-1:0] r_data;
  logic [CH_W-1:0]      r_channel;
  logic                 r_last;

  logic [RAM_WIDTH-1:0] w_heads [FIFOS_CNT];
  logic [FIFOS_CNT-1:0] w_eligible;
  logic [FIFOS_CNT-1:0] w_rd_en;
  logic [CH_W-1:0]      w_scan_ch;
  logic [CH_W-1:0]      w_next_ptr;
  logic                 w_found;
  logic                 w_load_en;
  logic                 w_head_valid;
  logic                 w_pop;
  logic                 w_last_word;
  logic                 w_burst_end;
  int                   w_idx;

  generate
    for (genvar gi = 0; gi < FIFOS_CNT; gi++) begin : g_head
      assign w_heads[gi] = drain.i_rd_data_channels[gi*RAM_WIDTH +: RAM_WIDTH];
    end
  endgenerate

`ifdef FIFO_DRAIN_CHANNEL_MASK_EN
  // The mask only gates new grants; an ongoing burst follows the FIFO valid alone.
  assign w_eligible = drain.i_rd_valid_channels & i_enable_channels;
`else
  assign w_eligible = drain.i_rd_valid_channels;
`endif

  // First eligible channel at or above rr_ptr, wrapping past the top channel.
  always_comb begin
    w_found   = 1'b0;
    w_scan_ch = '0;
    w_idx     = 0;
    for (int i = 0; i < FIFOS_CNT; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= FIFOS_CNT) w_idx = w_idx - FIFOS_CNT;
      if (!w_found && w_eligible[CH_W'(w_idx)]) begin
        w_found   = 1'b1;
        w_scan_ch = CH_W'(w_idx);
      end
    end
  end

  assign w_load_en    = !r_valid || drain.i_ready;
  assign w_head_valid = drain.i_rd_valid_channels[r_grant];
  assign w_pop        = (r_state == S_BURST) && w_head_valid && w_load_en;
  assign w_last_word  = (r_cnt == LAST_CNT) || drain.i_empty_next_channels[r_grant];
  // A burst ends on its last pop, or when the granted head vanishes while we could load.
  assign w_burst_end  = (r_state == S_BURST) && w_load_en && (!w_head_valid || w_last_word);
  assign w_next_ptr   = (r_grant == LAST_CH) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_rd_en = '0;
    if (w_pop) w_rd_en[r_grant] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SCAN:  if (w_found) w_state_next = S_BURST;
      S_BURST: if (w_burst_end) w_state_next = S_SCAN;
      default: w_state_next = S_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_SCAN;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_SCAN && w_found) begin
        r_grant <= w_scan_ch;
        r_cnt   <= '0;
      end
      if (w_pop) r_cnt <= r_cnt + 1'b1;
      if (w_burst_end) r_rr_ptr <= w_next_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_channel <= '0;
      r_last    <= 1'b0;
    end else if (w_pop) begin
      r_valid   <= 1'b1;
      r_data    <= w_heads[r_grant];
      r_channel <= r_grant;
      r_last    <= w_last_word;
    end else if (drain.i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign drain.o_rd_en_channels = w_rd_en;
  assign drain.o_valid          = r_valid;
  assign drain.o_data           = r_data;
  assign drain.o_channel        = r_channel;
  assign drain.o_last           = r_last;

endmodule

// File: tb/tb_fifo_multichannel_drain.sv
// Randomised bench: FIFO contents are modelled as per-channel queues and the expected
// output stream is computed from the round-robin burst rules before each drain phase.
module tb_fifo_multichannel_drain;
  localparam int RW   = 32;
  localparam int N    = 50;
  localparam int MB   = 16;
  localparam int CW   = $clog2(N);
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [RW-1:0] data;
    logic [CW-1:0] ch;
    logic          last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [N-1:0] en_mask;

  fifo_multichannel_drain_if #(.RAM_WIDTH(RW), .FIFOS_CNT(N)) bus ();

  fifo_multichannel_drain #(.RAM_WIDTH(RW), .FIFOS_CNT(N), .MAX_BURST(MB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
`ifdef FIFO_DRAIN_CHANNEL_MASK_EN
    .i_enable_channels (en_mask),
`endif
    .drain             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] fmem [N][DEPTH];
  int            fhead [N];
  int            fcnt  [N];
  logic [N-1:0]  forced;
  int            force_ch;
  int            force_pops;
  int            exp_ptr;
  exp_t          exp_q [$];
  int            xfer_ticks [$];
  int            tick_cnt;
  int            xfers;
  int            ready_mode;
  int            total_pops;
  bit            prev_stall;
  logic [RW-1:0] prev_data;
  logic [CW-1:0] prev_ch;
  logic          prev_last;
  int            n_checks;
  int            n_fail;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic load(input int ch, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      fmem[ch][(fhead[ch] + fcnt[ch]) % DEPTH] = (base < 0) ? RW'($urandom) : RW'(base + k);
      fcnt[ch]++;
    end
  endtask

  task automatic pop_word(input int ch);
    if (fcnt[ch] > 0) begin
      fhead[ch] = (fhead[ch] + 1) % DEPTH;
      fcnt[ch]--;
    end
  endtask

  // Expected stream: repeatedly grant the next non-empty eligible channel from the
  // round-robin pointer and take min(MAX_BURST, words left), last marked on the final word.
  function automatic void build_expected();
    int cnt [N];
    int hd  [N];
    int c;
    int found;
    int n;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      cnt[i] = fcnt[i];
      hd[i]  = fhead[i];
    end
    forever begin
      found = -1;
      for (int off = 0; off < N; off++) begin
        c = (exp_ptr + off) % N;
        if (found < 0 && cnt[c] > 0 && !forced[c] && en_mask[c]) found = c;
      end
      if (found < 0) break;
      n = (cnt[found] < MB) ? cnt[found] : MB;
      for (int k = 0; k < n; k++) begin
        e.data = fmem[found][(hd[found] + k) % DEPTH];
        e.ch   = CW'(found);
        e.last = (k == n - 1);
        exp_q.push_back(e);
      end
      hd[found]  = (hd[found] + n) % DEPTH;
      cnt[found] = cnt[found] - n;
      exp_ptr    = (found + 1) % N;
    end
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < N; c++) begin
      bus.i_rd_valid_channels[c]        = (fcnt[c] > 0) && !forced[c];
      bus.i_empty_next_channels[c]      = (fcnt[c] == 1);
      bus.i_rd_data_channels[c*RW +: RW] = (fcnt[c] > 0) ? fmem[c][fhead[c]] : '0;
    end
    case (ready_mode)
      0:       bus.i_ready = 1'b1;
      1:       bus.i_ready = ((tick_cnt % 4) == 0) || ((tick_cnt % 4) == 3);
      default: bus.i_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic monitor();
    logic [N-1:0] rd;
    exp_t e;
    rd = bus.o_rd_en_channels;
    check_eq("rd_en_onehot", 64'($countones(rd) <= 1), 64'd1);
    check_eq("pop_of_empty", 64'(rd & ~bus.i_rd_valid_channels), 64'd0);
    if (bus.o_valid && !bus.i_ready) check_eq("pop_in_stall", 64'(rd), 64'd0);
    if (prev_stall) begin
      check_eq("hold_valid", 64'(bus.o_valid), 64'd1);
      check_eq("hold_data", 64'(bus.o_data), 64'(prev_data));
      check_eq("hold_channel", 64'(bus.o_channel), 64'(prev_ch));
      check_eq("hold_last", 64'(bus.o_last), 64'(prev_last));
    end
    prev_stall = bus.o_valid && !bus.i_ready;
    prev_data  = bus.o_data;
    prev_ch    = bus.o_channel;
    prev_last  = bus.o_last;
    if (bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_word", 64'(bus.o_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("data", 64'(bus.o_data), 64'(e.data));
        check_eq("channel", 64'(bus.o_channel), 64'(e.ch));
        check_eq("last", 64'(bus.o_last), 64'(e.last));
        xfer_ticks.push_back(tick_cnt);
        xfers++;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] pm;
    drive_inputs();
    #1;
    monitor();
    pm = bus.o_rd_en_channels;
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      if (pm[c]) begin
        pop_word(c);
        total_pops++;
        if (c == force_ch) begin
          force_pops++;
          if (force_pops == 3) forced[c] = 1'b1;
        end
      end
    end
    @(negedge clk);
    tick_cnt++;
  endtask

  task automatic run_drain(input string name, input int mode, input int limit);
    int budget;
    int pops_before;
    int words;
    budget     = 5000;
    ready_mode = mode;
    tick_cnt   = 0;
    xfers      = 0;
    words      = exp_q.size();
    xfer_ticks.delete();
    while (exp_q.size() > 0 && tick_cnt < budget && (limit < 0 || xfers < limit)) tick();
    if (limit < 0) begin
      check_eq("drain_left", 64'(exp_q.size()), 64'd0);
      ready_mode  = 0;
      pops_before = total_pops;
      for (int i = 0; i < 4; i++) tick();
      check_eq("idle_pops", 64'(total_pops - pops_before), 64'd0);
    end
    $display("drain %s: %0d words expected, %0d received in %0d cycles", name, words, xfers, tick_cnt);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 64'(bus.o_valid), 64'd0);
    check_eq("rst_rd_en", 64'(bus.o_rd_en_channels), 64'd0);
    check_eq("rst_data", 64'(bus.o_data), 64'd0);
    check_eq("rst_channel", 64'(bus.o_channel), 64'd0);
    check_eq("rst_last", 64'(bus.o_last), 64'd0);
    exp_q.delete();
    exp_ptr    = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nch;
    int c;
    n_checks   = 0;
    n_fail     = 0;
    force_ch   = -1;
    force_pops = 0;
    forced     = '0;
    en_mask    = '1;
    exp_ptr    = 0;
    total_pops = 0;
    prev_stall = 1'b0;
    ready_mode = 0;
    tick_cnt   = 0;
    for (int i = 0; i < N; i++) begin
      fhead[i] = 0;
      fcnt[i]  = 0;
    end
    rst_n = 1'b0;
    bus.i_rd_valid_channels   = '0;
    bus.i_rd_data_channels    = '0;
    bus.i_empty_next_channels = '0;
    bus.i_ready               = 1'b0;

    // reset state
    #7;
    check_eq("init_valid", 64'(bus.o_valid), 64'd0);
    check_eq("init_data", 64'(bus.o_data), 64'd0);
    check_eq("init_channel", 64'(bus.o_channel), 64'd0);
    check_eq("init_last", 64'(bus.o_last), 64'd0);
    check_eq("init_rd_en", 64'(bus.o_rd_en_channels), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single channel, 20 words, two bursts
    load(3, 20, 1);
    build_expected();
    run_drain("single_ch3", 0, -1);
    check_eq("t1_xfers", 64'(xfers), 64'd20);
    if (xfer_ticks.size() == 20) begin
      check_eq("t1_first_tick", 64'(xfer_ticks[0]), 64'd2);
      check_eq("t1_w16_tick", 64'(xfer_ticks[15]), 64'd17);
      check_eq("t1_w17_tick", 64'(xfer_ticks[16]), 64'd19);
      check_eq("t1_w20_tick", 64'(xfer_ticks[19]), 64'd22);
    end
    check_eq("t1_fifo_left", 64'(fcnt[3]), 64'd0);

    // round robin order, then wrap back to channel 0
    do_reset();
    load(0, 2, -1);
    load(5, 2, -1);
    load(49, 2, -1);
    build_expected();
    run_drain("rr_0_5_49", 0, -1);
    load(0, 2, -1);
    build_expected();
    run_drain("rr_wrap_0", 0, -1);

    // backpressure pattern 1,0,0,1
    load(12, 10, -1);
    load(30, 5, -1);
    build_expected();
    run_drain("backpressure", 1, -1);

    // head lost after three pops on channel 7
    load(7, 10, -1);
    load(9, 3, -1);
    force_ch   = 7;
    force_pops = 0;
    for (int k = 0; k < 3; k++) exp_q.push_back('{fmem[7][(fhead[7] + k) % DEPTH], CW'(7), 1'b0});
    for (int k = 0; k < 3; k++) exp_q.push_back('{fmem[9][(fhead[9] + k) % DEPTH], CW'(9), (k == 2)});
    exp_ptr = 10;
    run_drain("head_lost_ch7", 0, -1);
    check_eq("t4_ch7_left", 64'(fcnt[7]), 64'd7);
    forced[7] = 1'b0;
    force_ch  = -1;
    build_expected();
    run_drain("ch7_resume", 0, -1);

    // asynchronous reset mid-burst
    load(10, 8, -1);
    load(20, 5, -1);
    build_expected();
    run_drain("pre_reset", 0, 3);
    check_eq("t5_xfers_before_rst", 64'(xfers), 64'd3);
    do_reset();
    load(4, 3, -1);
    build_expected();
    check_eq("t5_first_exp_ch", 64'(exp_q[0].ch), 64'd4);
    run_drain("post_reset", 0, -1);
    check_eq("t5_ch10_left", 64'(fcnt[10]), 64'd0);

`ifdef FIFO_DRAIN_CHANNEL_MASK_EN
    // channel mask
    en_mask[1] = 1'b0;
    load(1, 5, -1);
    load(2, 4, -1);
    build_expected();
    run_drain("mask_ch2_only", 0, -1);
    check_eq("t6_ch1_held", 64'(fcnt[1]), 64'd5);
    en_mask[1] = 1'b1;
    build_expected();
    run_drain("mask_ch1_enabled", 0, -1);
    check_eq("t6_ch1_left", 64'(fcnt[1]), 64'd0);
`endif

    // randomised phases
    for (int it = 0; it < 6; it++) begin
      nch = $urandom_range(1, 6);
      for (int k = 0; k < nch; k++) begin
        c = $urandom_range(0, N - 1);
        if (fcnt[c] == 0) load(c, $urandom_range(1, 40), -1);
      end
      build_expected();
      run_drain($sformatf("random_%0d", it), it % 3, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_multichannel_drain.md
# fifo_multichannel_drain

Round-robin drain arbiter sitting directly downstream of `fifo_multichannel`. It watches the per-channel first-word-fall-through read ports, grants one non-empty channel at a time, and pops up to `MAX_BURST` words from it. The popped words are serialised onto a single valid/ready stream, with a channel tag and a burst-end marker, for the readout/DMA stage.

## Interface
Parameters:
- `RAM_WIDTH`, 32, data word width; matches the FIFO.
- `FIFOS_CNT`, 50, number of FIFO channels; ≥ 2.
- `MAX_BURST`, 16, maximum words popped per grant; 1..256.

Ports:
- `clk`  in  1  single clock, shared with `fifo_multichannel`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_rd_valid_channels`  in  FIFOS_CNT  FIFO `o_rd_valid_channels`; a head word is present.
- `i_rd_data_channels`  in  FIFOS_CNT×RAM_WIDTH  FIFO `o_rd_data_channels`; head word.
- `i_empty_next_channels`  in  FIFOS_CNT  FIFO `o_empty_next_channels`; exactly one word remains.
- `o_rd_en_channels`  out  FIFOS_CNT  pop strobe to FIFO `i_rd_en_channels`; one-hot or zero.
- `o_valid`  out  1  output word valid.
- `o_data`  out  RAM_WIDTH  output word.
- `o_channel`  out  $clog2(FIFOS_CNT)  source channel of `o_data`.
- `o_last`  out  1  marks the last word of the current grant.
- `i_ready`  in  1  downstream accept.

## Operation
- The FSM has two states: `S_SCAN` and `S_BURST`. Reset enters `S_SCAN` with `rr_ptr`=0, `grant`=0 and `cnt`=0.
- **S_SCAN:** select the first eligible channel c with `i_rd_valid_channels[c]`=1, searching upward from `rr_ptr` with wrap-around.
  - If such a channel exists: `grant`<=c, `cnt`<=0, go to `S_BURST`.
  - Otherwise stay in `S_SCAN`.
  - No pops occur in `S_SCAN`.
- **load_en** = !`o_valid` | `i_ready`. The output register is single-entry.
- **Pop rule (S_BURST):** `o_rd_en_channels[grant]` = `i_rd_valid_channels[grant]` & `load_en`. This is combinational. All other bits are 0.
- **On a pop:**
  - `o_data`<=head word, `o_channel`<=`grant`, `o_valid`<=1, `cnt`<=`cnt`+1.
  - `o_last`<= (`cnt`==`MAX_BURST`-1) | `i_empty_next_channels[grant]`.
- **Burst end:** when the popped word has `o_last`=1, the FSM goes to `S_SCAN` and sets `rr_ptr`<=`grant`+1, wrapping from `FIFOS_CNT`-1 to 0.
- **Head lost mid-burst:** if the FSM is in `S_BURST` with `load_en`=1 but `i_rd_valid_channels[grant]`=0 (for example after a per-channel FIFO reset), it goes to `S_SCAN` with `rr_ptr`<=`grant`+1. No `o_last` is emitted for that burst.
- **Output register:** clears `o_valid` when `i_ready`=1 and no pop occurs in the same cycle. The output holds stable while `o_valid`=1 and `i_ready`=0.
- **Counter width:** `cnt` is $clog2(`MAX_BURST`)+1 bits and never exceeds `MAX_BURST`.
- **Reset mid-operation:** all outputs clear immediately; the in-flight output word is discarded. Words not yet popped remain in the FIFO.

## Timing
- **Reset values:**
  - `o_valid`=0, `o_data`=0, `o_channel`=0, `o_last`=0.
  - `o_rd_en_channels`=0, because the FSM resets to `S_SCAN`.
- **Latency:**
  - Channel becomes valid → first pop: 1 cycle (the scan cycle).
  - Pop → `o_valid`: 1 cycle (registered).
- **Throughput:** with `i_ready` held at 1, a full burst of N words takes N+1 cycles including the scan cycle.
- **Pop/data alignment:** the FIFO head word and `o_rd_en_channels` share a cycle. The next head word appears on the following cycle, per FIFO first-word-fall-through behaviour.
- **Backpressure:** when `i_ready`=0 while `o_valid`=1, `o_rd_en_channels` is 0 in that same cycle, so no word is lost.
- **Simultaneous requests:** round-robin fairness holds. A channel waits at most `FIFOS_CNT`-1 grants.

## Configuration
- Macro: `FIFO_DRAIN_CHANNEL_MASK_EN`.
- **Defined:** adds port `i_enable_channels` (in, FIFOS_CNT).
  - Eligibility in `S_SCAN` is `i_rd_valid_channels` & `i_enable_channels`.
  - Clearing a mask bit during that channel's burst does not abort the burst; it completes normally.
- **Undefined:** the port is absent and all channels are eligible.

## Test plan
1. **Single channel, multi-burst:** `MAX_BURST`=16, channel 3 holds 20 words (1..20), `i_ready`=1.
   - Output: 1..16 tagged ch 3 with `o_last` on 16, one scan gap, then 17..20 with `o_last` on 20.
   - No further `o_rd_en_channels` pulses.
2. **Round-robin order:** channels 0, 5 and 49 each hold 2 words.
   - Bursts appear in order 0, 5, 49, each with `o_last` on its second word.
   - Refilling channel 0 afterwards makes it the next grant after 49 (wrap).
3. **Backpressure:** `i_ready` toggles 1,0,0,1 during a burst.
   - `o_data`, `o_channel` and `o_last` hold stable while stalled.
   - No `o_rd_en_channels` pulse occurs in any cycle where `o_valid`=1 and `i_ready`=0.
   - All words arrive once, in order.
4. **Mid-burst channel reset:** force `i_rd_valid_channels[grant]` to 0 after 3 pops.
   - The FSM returns to `S_SCAN` with no `o_last`.
   - The next valid channel is granted.
5. **Async reset:** assert `rst_n`=0 mid-burst, off the clock edge.
   - `o_valid` and `o_rd_en_channels` go to 0 immediately.
   - After release, the first grant goes to the lowest-indexed valid channel.
6. **Mask (`FIFO_DRAIN_CHANNEL_MASK_EN` defined):** channels 1 and 2 are valid and `i_enable_channels[1]`=0.
   - Only channel 2 is drained.
   - Setting bit 1 leads to a channel 1 grant on the next scan.
